// File: rtl/register_bank_16x32.sv
// 16 x 32-bit register bank written through a one-hot select from the write decoder,
// with two independent registered read ports and a sticky illegal-select flag.
module register_bank_16x32 #(
   parameter int DATA_W    = 32,
   parameter int NUM_REGS  = 16,
   parameter int ADDR_W    = 4,
   parameter int ZERO_REG0 = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [NUM_REGS-1:0] wr_sel,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic                rd_en_a,
   input  logic [ADDR_W-1:0]   rd_addr_a,
   output logic [DATA_W-1:0]   rd_data_a,
   input  logic                rd_en_b,
   input  logic [ADDR_W-1:0]   rd_addr_b,
   output logic [DATA_W-1:0]   rd_data_b,
   output logic                wr_err,
   input  logic                err_clr
);

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   rd_data_a_q, rd_data_a_d;
   logic [DATA_W-1:0]   rd_data_b_q, rd_data_b_d;
   logic                wr_err_q, wr_err_d;
   logic                wr_onehot;
   logic [NUM_REGS-1:0] wr_hit;

   assign wr_onehot = $onehot(wr_sel);

   // wr_hit marks the single register a legal write updates this edge; a hardwired
   // R0 is never hit, which also keeps the read bypass away from it.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      wr_hit = '0;
      if (wr_en && wr_onehot) begin
         wr_hit = wr_sel;
      end
      if (ZERO_REG0 != 0) begin
         wr_hit[0] = 1'b0;
      end
   end

   always_comb begin
      rd_data_a_d = rd_data_a_q;
      rd_data_b_d = rd_data_b_q;
      if (rd_en_a) begin
         rd_data_a_d = wr_hit[rd_addr_a] ? wr_data : regs_q[rd_addr_a];
      end
      if (rd_en_b) begin
         rd_data_b_d = wr_hit[rd_addr_b] ? wr_data : regs_q[rd_addr_b];
      end
   end

   // Set has priority over clear so a fault coincident with err_clr is not lost.
   always_comb begin
      wr_err_d = wr_err_q;
      if (wr_en && !wr_onehot) begin
         wr_err_d = 1'b1;
      end else if (err_clr) begin
         wr_err_d = 1'b0;
      end
   end

   // NOTE: the register array is reset explicitly; the bank must read back 0 after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            // NOTE: sequential state uses non-blocking assignments only.
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_hit[i]) begin
               regs_q[i] <= wr_data;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_a_q <= '0;
         rd_data_b_q <= '0;
         wr_err_q    <= 1'b0;
      end else begin
         rd_data_a_q <= rd_data_a_d;
         rd_data_b_q <= rd_data_b_d;
         wr_err_q    <= wr_err_d;
      end
   end

   assign rd_data_a = rd_data_a_q;
   assign rd_data_b = rd_data_b_q;
   assign wr_err    = wr_err_q;

endmodule
